// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared opcode/state encodings and opcode classification
//               helpers for the GPU command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    // Host opcode space; only CLEAR..DRAW_LINE are executed by the decoder.
    typedef enum logic [3:0] {
        OP_CLEAR       = 4'd0,
        OP_SET_XY1     = 4'd1,
        OP_SET_XY2     = 4'd2,
        OP_SET_RADIUS  = 4'd3,
        OP_DRAW_LINE   = 4'd4,
        OP_DRAW_CIRCLE = 4'd5,
        OP_FILL_RECT   = 4'd6,
        OP_DRAW_ARC    = 4'd7
    } gpu_opcode_t;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        INIT      = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DRAW = 3'd3,
        RELEASE   = 3'd4,
        SETTLE    = 3'd5
    } sched_state_t;

    // Opcodes are passed zero-extended so the helpers work for any OP_W.
    function automatic logic is_supported_op(input logic [31:0] op);
        return (op <= 32'(OP_DRAW_LINE));
    endfunction

    function automatic logic is_draw_op(input logic [31:0] op);
        return (op == 32'(OP_DRAW_LINE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gpu_cmd_fifo
// Description : Show-ahead synchronous FIFO holding opcode/parameter words
//               between the host interface and the scheduler FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_cmd_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 29
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW:0]   c_CNT_MAX = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign w_do_push = i_push && !o_full  && !i_flush;
    assign w_do_pop  = i_pop  && !o_empty && !i_flush;

    assign o_full  = (r_count == c_CNT_MAX);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally modulo the power-of-two depth.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gpu_cmd_scheduler
// Description : Buffers host commands and issues them to the GPU command
//               decoder one at a time, handshaking draw completion with the
//               rasterizer and covering the decoder's restart cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_cmd_scheduler
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int OP_W           = 4,
    parameter int PARAM_W        = 25,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [OP_W-1:0]               cmd_opcode_i,
    input  logic [PARAM_W-1:0]            cmd_params_i,
    input  logic                          flush_i,
    input  logic                          draw_done_i,
    output logic [OP_W-1:0]               opcode_o,
    output logic [PARAM_W-1:0]            parameters_o,
    output logic                          command_o,
    output logic                          finished_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          err_opcode_o,
    output logic                          timeout_o
);

    localparam int c_DATA_W = OP_W + PARAM_W;
    localparam int c_TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;

    logic [c_DATA_W-1:0]  w_head;
    logic [OP_W-1:0]      w_head_op;
    logic [PARAM_W-1:0]   w_head_par;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    logic [OP_W-1:0]      r_opcode;
    logic [PARAM_W-1:0]   r_params;
    logic                 r_err_opcode;
    logic                 r_timeout;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [31:0]          w_cnt_inc;
    logic                 w_tmo_hit;

    logic                 w_command;
    logic                 w_finished;
    logic                 w_drop;
    logic                 w_tmo_set;
    logic                 w_cnt_clr;

    // Ready is a pure function of occupancy; a same-cycle pop never helps.
    assign cmd_ready_o = !w_full;
    assign w_push      = cmd_valid_i && !w_full && !flush_i;

    assign w_head_op   = w_head[c_DATA_W-1:PARAM_W];
    assign w_head_par  = w_head[PARAM_W-1:0];

    gpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .i_wdata ({cmd_opcode_i, cmd_params_i}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count_o),
        .o_head  (w_head)
    );

    // The timeout fires in the WAIT_DRAW cycle whose increment reaches
    // TIMEOUT_CYCLES-1, so RELEASE lands TIMEOUT_CYCLES cycles after ISSUE.
    assign w_cnt_inc = 32'(r_tmo_cnt) + 32'd1;
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) &&
                       (w_cnt_inc >= (32'(TIMEOUT_CYCLES) - 32'd1));

    // State register; reset drops any in-flight command.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_drop      = 1'b0;
        w_tmo_set   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_command   = 1'b0;
        w_finished  = 1'b0;
        case (r_state)
            INIT: begin
                w_state_nxt = IDLE;
            end
            IDLE: begin
                if (!w_empty && !flush_i) begin
                    w_pop = 1'b1;
                    if (is_supported_op(32'(w_head_op))) begin
                        w_state_nxt = ISSUE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_command = 1'b1;
                if (is_draw_op(32'(r_opcode))) begin
                    w_state_nxt = WAIT_DRAW;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DRAW: begin
                if (draw_done_i) begin
                    w_state_nxt = RELEASE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RELEASE;
                    w_tmo_set   = 1'b1;
                end
            end
            RELEASE: begin
                w_finished  = 1'b1;
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    // Every pop (supported or not) updates the decoder-facing registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_opcode <= '0;
            r_params <= '0;
        end else if (w_pop) begin
            r_opcode <= w_head_op;
            r_params <= w_head_par;
        end
    end

    // Draw timeout counter, cleared on the way into WAIT_DRAW.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tmo_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_DRAW) begin
            r_tmo_cnt <= w_cnt_inc[c_TMO_W-1:0];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_opcode <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_drop) begin
                r_err_opcode <= 1'b1;
            end
            if (w_tmo_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign opcode_o     = r_opcode;
    assign parameters_o = r_params;
    assign command_o    = w_command;
    assign finished_o   = w_finished;
    assign err_opcode_o = r_err_opcode;
    assign timeout_o    = r_timeout;
    // INIT is treated as quiescent so busy_o is low coming out of reset.
    assign busy_o       = ((r_state != IDLE) && (r_state != INIT)) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_cmd_scheduler
// Description : Directed self-checking bench for gpu_cmd_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_cmd_scheduler;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [3:0]  cmd_opcode_i = '0;
    logic [24:0] cmd_params_i = '0;
    logic        flush_i = 1'b0;
    logic        draw_done_i = 1'b0;
    logic [3:0]  opcode_o;
    logic [24:0] parameters_o;
    logic        command_o;
    logic        finished_o;
    logic        busy_o;
    logic [3:0]  fifo_count_o;
    logic        err_opcode_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int max_count = 0;

    int          cmd_cyc_q[$];
    logic [3:0]  cmd_op_q[$];
    logic [24:0] cmd_par_q[$];
    int          fin_cyc_q[$];

    gpu_cmd_scheduler #(
        .FIFO_DEPTH     (8),
        .OP_W           (4),
        .PARAM_W        (25),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_opcode_i (cmd_opcode_i),
        .cmd_params_i (cmd_params_i),
        .flush_i      (flush_i),
        .draw_done_i  (draw_done_i),
        .opcode_o     (opcode_o),
        .parameters_o (parameters_o),
        .command_o    (command_o),
        .finished_o   (finished_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o),
        .err_opcode_o (err_opcode_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    // Cycle index advances on each active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Record decoder-facing pulses on the inactive edge.
    always @(negedge clk) begin
        if (n_rst) begin
            if (command_o) begin
                cmd_cyc_q.push_back(cyc);
                cmd_op_q.push_back(opcode_o);
                cmd_par_q.push_back(parameters_o);
            end
            if (finished_o) begin
                fin_cyc_q.push_back(cyc);
            end
            if (int'(fifo_count_o) > max_count) begin
                max_count <= int'(fifo_count_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clr_q();
        cmd_cyc_q.delete();
        cmd_op_q.delete();
        cmd_par_q.delete();
        fin_cyc_q.delete();
    endtask

    // Called just after an active edge; holds valid until accepted.
    task automatic push(input logic [3:0] op, input logic [24:0] par);
        bit done;
        done = 1'b0;
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = op;
        cmd_params_i = par;
        for (int i = 0; i < 60 && !done; i++) begin
            if (cmd_ready_o) done = 1'b1;
            tick();
        end
        cmd_valid_i = 1'b0;
        if (!done) chk("push_accept_timeout", 32'd0, 32'd1);
    endtask

    // Returns one cycle after the n-th recorded command pulse.
    task automatic wait_cmd(input int n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (cmd_cyc_q.size() >= n) done = 1'b1;
        end
        if (!done) chk("wait_cmd_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset values while reset is held
        idle(3);
        chk("rst_command",  32'(command_o),    32'd0);
        chk("rst_finished", 32'(finished_o),   32'd0);
        chk("rst_opcode",   32'(opcode_o),     32'd0);
        chk("rst_params",   32'(parameters_o), 32'd0);
        chk("rst_err",      32'(err_opcode_o), 32'd0);
        chk("rst_timeout",  32'(timeout_o),    32'd0);
        chk("rst_count",    32'(fifo_count_o), 32'd0);
        n_rst = 1'b1;

        // Two back-to-back setup commands
        clr_q();
        push(4'd1, 25'h00A014);
        push(4'd2, 25'h01E028);
        idle(8);
        chk("t1_ncmd",  32'(cmd_cyc_q.size()), 32'd2);
        chk("t1_op0",   32'(cmd_op_q[0]),  32'd1);
        chk("t1_par0",  32'(cmd_par_q[0]), 32'h00A014);
        chk("t1_op1",   32'(cmd_op_q[1]),  32'd2);
        chk("t1_par1",  32'(cmd_par_q[1]), 32'h01E028);
        chk("t1_gap",   32'(cmd_cyc_q[1] - cmd_cyc_q[0]), 32'd2);
        chk("t1_nfin",  32'(fin_cyc_q.size()), 32'd0);
        chk("t1_busy",  32'(busy_o), 32'd0);
        chk("t1_ready", 32'(cmd_ready_o), 32'd1);
        // draw_done outside WAIT_DRAW is ignored
        draw_done_i = 1'b1;
        tick();
        draw_done_i = 1'b0;
        idle(3);
        chk("t1_stray_done", 32'(fin_cyc_q.size()), 32'd0);

        // Draw with completion five cycles after ISSUE, CLEAR queued behind
        clr_q();
        push(4'd4, 25'hFF00AA);
        wait_cmd(1);
        push(4'd0, 25'h000123);
        idle(3);
        draw_done_i = 1'b1;
        tick();
        draw_done_i = 1'b0;
        idle(10);
        chk("t2_ncmd",    32'(cmd_cyc_q.size()), 32'd2);
        chk("t2_op0",     32'(cmd_op_q[0]),  32'd4);
        chk("t2_par0",    32'(cmd_par_q[0]), 32'hFF00AA);
        chk("t2_nfin",    32'(fin_cyc_q.size()), 32'd1);
        chk("t2_fin_lat", 32'(fin_cyc_q[0] - cmd_cyc_q[0]), 32'd6);
        chk("t2_restart", 32'(cmd_cyc_q[1] - fin_cyc_q[0]), 32'd3);
        chk("t2_op1",     32'(cmd_op_q[1]), 32'd0);
        chk("t2_timeout", 32'(timeout_o), 32'd0);

        // Draw that never completes: forced release after 16 cycles
        clr_q();
        push(4'd4, 25'h000001);
        wait_cmd(1);
        idle(30);
        chk("t3_nfin",    32'(fin_cyc_q.size()), 32'd1);
        chk("t3_fin_lat", 32'(fin_cyc_q[0] - cmd_cyc_q[0]), 32'd16);
        chk("t3_timeout", 32'(timeout_o), 32'd1);
        chk("t3_err",     32'(err_opcode_o), 32'd0);

        // Unsupported opcode dropped, following setup opcode issues
        clr_q();
        push(4'd6, 25'h000005);
        push(4'd3, 25'h000007);
        idle(6);
        chk("t4_ncmd",    32'(cmd_cyc_q.size()), 32'd1);
        chk("t4_op",      32'(cmd_op_q[0]),  32'd3);
        chk("t4_par",     32'(cmd_par_q[0]), 32'd7);
        chk("t4_err",     32'(err_opcode_o), 32'd1);
        chk("t4_tmo_sticky", 32'(timeout_o), 32'd1);

        // Fill the FIFO while a draw is stalled
        clr_q();
        push(4'd4, 25'h000002);
        wait_cmd(1);
        for (int i = 0; i < 8; i++) push(4'd1, 25'(i));
        chk("t5_count_full", 32'(fifo_count_o), 32'd8);
        chk("t5_ready_full", 32'(cmd_ready_o),  32'd0);
        fork
            push(4'd1, 25'd9);
            begin
                tick();
                draw_done_i = 1'b1;
                tick();
                draw_done_i = 1'b0;
            end
        join
        idle(40);
        chk("t5_ncmd",    32'(cmd_cyc_q.size()), 32'd10);
        chk("t5_last",    32'(cmd_par_q[9]), 32'd9);
        chk("t5_nfin",    32'(fin_cyc_q.size()), 32'd1);
        chk("t5_maxcnt",  32'(max_count), 32'd8);
        chk("t5_drained", 32'(fifo_count_o), 32'd0);

        // Flush during WAIT_DRAW
        clr_q();
        push(4'd4, 25'h000003);
        wait_cmd(1);
        for (int i = 0; i < 5; i++) push(4'd2, 25'(i));
        chk("t6_count5", 32'(fifo_count_o), 32'd5);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t6_flushed", 32'(fifo_count_o), 32'd0);
        draw_done_i = 1'b1;
        tick();
        draw_done_i = 1'b0;
        idle(10);
        chk("t6_nfin",    32'(fin_cyc_q.size()), 32'd1);
        chk("t6_fin_lat", 32'(fin_cyc_q[0] - cmd_cyc_q[0]), 32'd8);
        chk("t6_ncmd",    32'(cmd_cyc_q.size()), 32'd1);
        chk("t6_busy",    32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
